// File: rtl/rca_pkg.sv
// Shared types and default sizes for the ripple-carry accumulator slice.
// Benches import the same defaults so widths stay in lockstep.
package rca_pkg;

    localparam int RCA_N     = 4;
    localparam int RCA_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/rca_nbit.sv
// N-bit ripple-carry adder built from a chain of full-adder cells.
// Purely combinational; the carry ripples from bit 0 upward.
module rca_nbit #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[N];

endmodule

// File: rtl/rca_accumulator.sv
// Burst accumulator: sums operands through rca_nbit, tracks a sticky
// carry and a saturating beat count, then holds the result for a consumer.
module rca_accumulator
    import rca_pkg::*;
#(
    parameter int N     = RCA_N,
    parameter int CNT_W = RCA_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_sum,
    output logic             out_carry,
    output logic [CNT_W-1:0] out_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state;
    state_t             state_n;
    logic [N-1:0]       acc;
    logic               ovf;
    logic [CNT_W-1:0]   cnt;
    logic [N-1:0]       sum;
    logic               cout;
    logic               beat;
    logic               take;

    rca_nbit #(.N(N)) u_add (
        .a    (acc),
        .b    (in_data),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // Handshake flags come from registered state only.
    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE, ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_n = in_last ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign beat = in_valid && in_ready;
    assign take = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            ovf   <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            if (beat) begin
                acc <= sum;
                ovf <= ovf | cout;
                if (cnt != CNT_MAX) begin
                    cnt <= cnt + 1'b1;
                end
            end else if (take) begin
                acc <= '0;
                ovf <= 1'b0;
                cnt <= '0;
            end
        end
    end

    assign out_sum   = acc;
    assign out_carry = ovf;
    assign out_count = cnt;

endmodule

// File: tb/tb_rca_accumulator.sv
// Directed plus randomized bench for rca_accumulator against an
// arithmetic reference model of the burst sum, carry and count.
module tb_rca_accumulator;
    import rca_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_sum;
    logic       out_carry;
    logic [3:0] out_count;

    int n_cmp = 0;
    int n_bad = 0;

    int m_sum   = 0;
    bit m_carry = 1'b0;
    int m_cnt   = 0;
    bit m_hold  = 1'b0;

    rca_accumulator #(.N(RCA_N), .CNT_W(RCA_CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        m_sum   = 0;
        m_carry = 1'b0;
        m_cnt   = 0;
        m_hold  = 1'b0;
    endtask

    task automatic cyc(input bit v, input int d, input bit l,
                       input bit r, input bit rs);
        in_valid  = v;
        in_data   = d[3:0];
        in_last   = l;
        out_ready = r;
        rst       = rs;
        if (rs) begin
            clear_model();
        end else if (!m_hold) begin
            if (v) begin
                int t;
                t = m_sum + (d % 16);
                if (t > 15) m_carry = 1'b1;
                m_sum = t % 16;
                if (m_cnt < 15) m_cnt++;
                if (l) m_hold = 1'b1;
            end
        end else if (r) begin
            clear_model();
        end
        @(posedge clk);
        #1;
        chk("in_ready",  int'(in_ready),  int'(!m_hold));
        chk("out_valid", int'(out_valid), int'(m_hold));
        chk("out_sum",   int'(out_sum),   m_sum);
        chk("out_carry", int'(out_carry), int'(m_carry));
        chk("out_count", int'(out_count), m_cnt);
    endtask

    task automatic drain();
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_valid", int'(out_valid), 0);

        cyc(1'b1, 3, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 4, 1'b1, 1'b1, 1'b0);
        chk("two_sum", int'(out_sum), 7);
        chk("two_carry", int'(out_carry), 0);
        chk("two_count", int'(out_count), 2);
        drain();
        chk("two_idle", int'(out_valid), 0);

        cyc(1'b1, 9, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 9, 1'b1, 1'b1, 1'b0);
        chk("ovf_sum", int'(out_sum), 2);
        chk("ovf_carry", int'(out_carry), 1);
        chk("ovf_count", int'(out_count), 2);
        drain();
        cyc(1'b1, 1, 1'b1, 1'b1, 1'b0);
        chk("sticky_clr", int'(out_carry), 0);
        chk("single_sum", int'(out_sum), 1);
        drain();

        cyc(1'b1, 15, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 5, 1'b0, 1'b0, 1'b0);
            chk("bp_ready", int'(in_ready), 0);
            chk("bp_sum", int'(out_sum), 15);
            chk("bp_count", int'(out_count), 1);
        end
        cyc(1'b1, 5, 1'b0, 1'b1, 1'b0);
        chk("bp_open", int'(in_ready), 1);
        cyc(1'b1, 5, 1'b1, 1'b1, 1'b0);
        chk("bp_next", int'(out_sum), 5);
        drain();

        for (int i = 0; i < 17; i++) begin
            cyc(1'b1, 0, i == 16, 1'b1, 1'b0);
        end
        chk("sat_count", int'(out_count), 15);
        chk("sat_sum", int'(out_sum), 0);
        chk("sat_carry", int'(out_carry), 0);
        drain();

        cyc(1'b1, 6, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 7, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1, 1'b0, 1'b1, 1'b1);
        chk("rstmid_sum", int'(out_sum), 0);
        chk("rstmid_count", int'(out_count), 0);
        cyc(1'b1, 2, 1'b1, 1'b1, 1'b0);
        chk("after_rst_sum", int'(out_sum), 2);
        chk("after_rst_count", int'(out_count), 1);
        drain();

        cyc(1'b1, 3, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b1);
        chk("rsthold_valid", int'(out_valid), 0);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
        chk("rsthold_stay", int'(out_valid), 0);

        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(3) != 0, int'($urandom_range(15)),
                $urandom_range(5) == 0, $urandom_range(1) == 1,
                $urandom_range(49) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
